// File: rtl/pwm_duty_gen.sv
`default_nettype none
// ============================================================================
// pwm_duty_gen : switch-stepped duty level (0..9) driving a 10-tick motor PWM
// Revision     : 1.0
// ============================================================================
module pwm_duty_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       motor_running,
    input  logic       swt_increase,
    input  logic       swt_decrease,
    output logic       pwm_out,
    output logic [3:0] duty_level,
    output logic [6:0] display
);

    localparam int             PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [3:0]     LEVEL_MAX  = 4'd9;
    localparam logic [3:0]     LEVEL_INIT = 4'd5;
    localparam logic [3:0]     PHASE_LAST = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [3:0]    duty_q;
    logic [3:0]    duty_d;
    logic [3:0]    active_q;
    logic [3:0]    phase_q;
    logic [PW-1:0] presc_q;
    logic          pwm_q;

    logic inc_meta_q, inc_sync_q, inc_hist_q;
    logic dec_meta_q, dec_sync_q, dec_hist_q;
    logic inc_pulse, dec_pulse;
    logic tick, wrap;

    // Two-flop synchronizer plus history flop gives one pulse per rising change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_meta_q <= 1'b0;
            inc_sync_q <= 1'b0;
            inc_hist_q <= 1'b0;
            dec_meta_q <= 1'b0;
            dec_sync_q <= 1'b0;
            dec_hist_q <= 1'b0;
        end else begin
            inc_meta_q <= swt_increase;
            inc_sync_q <= inc_meta_q;
            inc_hist_q <= inc_sync_q;
            dec_meta_q <= swt_decrease;
            dec_sync_q <= dec_meta_q;
            dec_hist_q <= dec_sync_q;
        end
    end

    assign inc_pulse = inc_sync_q & ~inc_hist_q;
    assign dec_pulse = dec_sync_q & ~dec_hist_q;
    assign tick      = (presc_q == PRESC_LAST);
    assign wrap      = tick && (phase_q == PHASE_LAST);

    always_comb begin
        duty_d = duty_q;
        if (inc_pulse && !dec_pulse && (duty_q < LEVEL_MAX)) begin
            duty_d = duty_q + 4'd1;
        end else if (dec_pulse && !inc_pulse && (duty_q != 4'd0)) begin
            duty_d = duty_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            duty_q   <= 4'd0;
            active_q <= 4'd0;
            phase_q  <= 4'd0;
            presc_q  <= '0;
            pwm_q    <= 1'b0;
        end else begin
            pwm_q <= (state_q == ST_RUN) && (phase_q < active_q);
            case (state_q)
                ST_IDLE: begin
                    presc_q <= '0;
                    phase_q <= 4'd0;
                    if (motor_running) begin
                        state_q  <= ST_RUN;
                        duty_q   <= LEVEL_INIT;
                        active_q <= LEVEL_INIT;
                    end else begin
                        duty_q   <= 4'd0;
                        active_q <= 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!motor_running) begin
                        state_q  <= ST_IDLE;
                        duty_q   <= 4'd0;
                        active_q <= 4'd0;
                        phase_q  <= 4'd0;
                        presc_q  <= '0;
                    end else begin
                        duty_q  <= duty_d;
                        presc_q <= tick ? '0 : (presc_q + PRESC_ONE);
                        if (tick) begin
                            phase_q <= wrap ? 4'd0 : (phase_q + 4'd1);
                        end
                        // New duty is only adopted at a period boundary.
                        if (wrap) begin
                            active_q <= duty_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (duty_q)
            4'd0:    display = 7'b1000000;
            4'd1:    display = 7'b1111001;
            4'd2:    display = 7'b0100100;
            4'd3:    display = 7'b0110000;
            4'd4:    display = 7'b0011001;
            4'd5:    display = 7'b0010010;
            4'd6:    display = 7'b0000010;
            4'd7:    display = 7'b1111000;
            4'd8:    display = 7'b0000000;
            4'd9:    display = 7'b0010000;
            default: display = 7'b1111111;
        endcase
    end

    assign pwm_out    = pwm_q;
    assign duty_level = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_gen.sv
`default_nettype none
// ============================================================================
// tb_pwm_duty_gen : table-driven and randomized checks against a cycle model
// Revision        : 1.0
// ============================================================================
module tb_pwm_duty_gen;

    localparam int P = 4;

    logic       clk;
    logic       rst;
    logic       motor_running;
    logic       swt_increase;
    logic       swt_decrease;
    logic       pwm_out;
    logic [3:0] duty_level;
    logic [6:0] display;

    pwm_duty_gen #(.PRESCALE(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .motor_running(motor_running),
        .swt_increase (swt_increase),
        .swt_decrease (swt_decrease),
        .pwm_out      (pwm_out),
        .duty_level   (duty_level),
        .display      (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] disp_tab [10];

    // Reference model: run time since start, sampled-switch history, levels.
    int m_run, m_n, m_duty, m_active, m_pwm;
    bit ih [3];
    bit dh [3];

    typedef struct {
        bit inc;
        bit dec;
        int exp_duty;
    } press_t;
    press_t presses [16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_n = 0; m_duty = 0; m_active = 0; m_pwm = 0;
        for (int i = 0; i < 3; i++) begin
            ih[i] = 1'b0;
            dh[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit r, input bit mr, input bit inc, input bit dec);
        int ph;
        int new_pwm;
        bit inc_step, dec_step;
        if (r) begin
            model_reset();
            return;
        end
        ph       = (m_n / P) % 10;
        new_pwm  = (m_run != 0 && ph < m_active) ? 1 : 0;
        inc_step = ih[1] && !ih[2];
        dec_step = dh[1] && !dh[2];
        ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = inc;
        dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = dec;
        if (m_run == 0) begin
            m_n = 0;
            if (mr) begin
                m_run = 1; m_duty = 5; m_active = 5;
            end else begin
                m_duty = 0; m_active = 0;
            end
        end else if (!mr) begin
            m_run = 0; m_n = 0; m_duty = 0; m_active = 0;
        end else begin
            if ((m_n + 1) % (10 * P) == 0) m_active = m_duty;
            m_n++;
            if (inc_step && !dec_step && m_duty < 9) m_duty++;
            else if (dec_step && !inc_step && m_duty > 0) m_duty--;
        end
        m_pwm = new_pwm;
    endfunction

    // Drive at negedge, let the model see the same edge, compare at next negedge.
    task automatic step(input bit r, input bit mr, input bit inc, input bit dec);
        rst           = r;
        motor_running = mr;
        swt_increase  = inc;
        swt_decrease  = dec;
        @(posedge clk);
        model_edge(r, mr, inc, dec);
        @(negedge clk);
        chk("model_duty", int'(duty_level), m_duty);
        chk("model_pwm", int'(pwm_out), m_pwm);
        chk("model_display", int'(display), int'(disp_tab[m_duty]));
    endtask

    task automatic press(input bit inc, input bit dec);
        step(1'b0, 1'b1, inc, dec);
        step(1'b0, 1'b1, inc, dec);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic count_high(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (pwm_out) cnt++;
        end
    endtask

    task automatic wait_pwm_high(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (pwm_out) found = 1'b1;
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int base;
        bit r_mr, r_inc, r_dec, r_rst;

        disp_tab[0] = 7'b1000000; disp_tab[1] = 7'b1111001;
        disp_tab[2] = 7'b0100100; disp_tab[3] = 7'b0110000;
        disp_tab[4] = 7'b0011001; disp_tab[5] = 7'b0010010;
        disp_tab[6] = 7'b0000010; disp_tab[7] = 7'b1111000;
        disp_tab[8] = 7'b0000000; disp_tab[9] = 7'b0010000;

        for (int i = 0; i < 6; i++) presses[i] = '{1'b1, 1'b0, (5 + i + 1 > 9) ? 9 : 5 + i + 1};
        for (int i = 6; i < 16; i++) presses[i] = '{1'b0, 1'b1, (14 - i < 0) ? 0 : 14 - i};

        rst = 1'b1; motor_running = 1'b0; swt_increase = 1'b0; swt_decrease = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_duty", int'(duty_level), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_display", int'(display), int'(7'b1000000));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Start: level 5, 20 high / 20 low.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_duty", int'(duty_level), 5);
        chk("start_display", int'(display), int'(7'b0010010));
        count_high(40, cnt);
        chk("start_high_cycles", cnt, 20);

        for (int i = 0; i < 6; i++) begin
            press(presses[i].inc, presses[i].dec);
            chk($sformatf("press_%0d", i), int'(duty_level), presses[i].exp_duty);
        end
        count_high(80, cnt);
        count_high(40, cnt);
        chk("sat9_high_cycles", cnt, 36);

        for (int i = 6; i < 16; i++) begin
            press(presses[i].inc, presses[i].dec);
            chk($sformatf("press_%0d", i), int'(duty_level), presses[i].exp_duty);
        end
        count_high(80, cnt);
        count_high(40, cnt);
        chk("sat0_high_cycles", cnt, 0);

        // Both switches together, then a long hold.
        press(1'b1, 1'b0);
        chk("inc_from_0", int'(duty_level), 1);
        press(1'b1, 1'b1);
        chk("both_pressed", int'(duty_level), 1);
        base = int'(duty_level);
        for (int k = 1; k <= 100; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            chk("hold_inc", int'(duty_level), (k >= 3) ? base + 1 : base);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Stop while the output is high, then restart.
        count_high(80, cnt);
        wait_pwm_high("pwm_high_before_stop");
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop_duty", int'(duty_level), 0);
        chk("stop_display", int'(display), int'(7'b1000000));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop_pwm", int'(pwm_out), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("restart_duty", int'(duty_level), 5);
        count_high(40, cnt);
        chk("restart_high_cycles", cnt, 20);

        // Asynchronous reset between edges.
        wait_pwm_high("pwm_high_before_rst");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_duty", int'(duty_level), 0);
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_display", int'(display), int'(7'b1000000));
        model_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("post_rst_idle", int'(duty_level), 0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_start", int'(duty_level), 5);

        // Randomized traffic against the model.
        r_mr = 1'b1; r_inc = 1'b0; r_dec = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) r_mr = ~r_mr;
            if ($urandom_range(0, 7) == 0) r_inc = ~r_inc;
            if ($urandom_range(0, 7) == 0) r_dec = ~r_dec;
            r_rst = ($urandom_range(0, 999) == 0);
            step(r_rst, r_mr, r_inc, r_dec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
